lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Initiator side of the word-only data memory interface in the MEM stage.
- Accepts one load/store request at a time from the pipeline using RV32 funct3 encodings.
- Issues word-aligned read/write strobes to the data memory and returns a sign- or zero-extended load result.
- Performs read-modify-write for byte and halfword stores, because the memory only writes full words.

Parameters:
- WIDTH, 32, datapath/address width (package value from all_pkgs). Only 32 is supported because byte-lane logic assumes 4 lanes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a clk edge
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data; low byte/half is used for SB/SH
- resp_valid  output  1  one-cycle pulse, request complete
- resp_err  output  1  valid with resp_valid; misaligned address or illegal funct3
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors
- mem_rd_en  output  1  memory read strobe (asynchronous read)
- mem_wr_en  output  1  memory write strobe (write commits at the clk edge)
- mem_addr  output  WIDTH  {latched_addr[WIDTH-1:2], 2'b00}
- mem_wr_data  output  WIDTH  full word to write
- mem_rd_data  input  WIDTH  read word from memory

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - resp_valid, resp_err, mem_rd_en, mem_wr_en = 0.
  - resp_rdata, mem_addr, mem_wr_data, and all latched registers = 0.
  - req_ready = 1.
- Memory-side outputs are Moore: decoded from state and latched registers only. No combinational path exists from req_* to mem_*.
- On accept, latch we, funct3, addr, and wdata. Then decode:
  - Illegal: store with funct3 not in {000,001,010}; load with funct3 in {011,110,111}.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal or misaligned goes to RESP with err=1. No memory strobe is issued.
- States:
  - IDLE: req_ready=1. On accept, go to LOAD (load), WRITE (SW), RMW_RD (SB/SH), or RESP (error).
  - LOAD: mem_rd_en=1. Capture the extended lane of mem_rd_data into resp_rdata at the clock edge, then go to RESP.
  - RMW_RD: mem_rd_en=1. Capture the merged word into the write-data register, then go to WRITE.
  - WRITE: mem_wr_en=1, mem_wr_data = word register, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in this state, so there is no back-to-back accept.
- Lane selection: byte lane = addr[1:0]; half lane = addr[1].
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.
- Store merge:
  - SB: word = (old & ~(0xFF << 8*lane)) | (wdata[7:0] << 8*lane).
  - SH: same form with a 16-bit mask and wdata[15:0].
  - SW: wdata is written unchanged.
- Latency, counted from the accept edge (cycle 0): resp_valid is high in
  - cycle 2 for LW/LB/LH/LBU/LHU and SW;
  - cycle 3 for SB/SH;
  - cycle 1 for errors.
- resp_rdata holds its value until the next load completes. A store or error response drives it to 0 in its RESP cycle.
- Reset mid-operation:
  - All strobes drop immediately and state returns to IDLE.
  - A pending RMW write is discarded, so memory is unchanged.
  - resp_valid is never produced for the aborted request.
- req_valid held high across RESP is not accepted until the next IDLE cycle.
- Address bits above [9:2] are passed through on mem_addr. They are not range-checked.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=1, resp_valid=0, mem_rd_en=0, mem_wr_en=0. No request is accepted until rst_n=1.
- SW addr 0x10 data 0xDEADBEEF → cycle 1: mem_wr_en=1, mem_addr=0x10, mem_wr_data=0xDEADBEEF. Cycle 2: resp_valid=1, resp_err=0. Then LW 0x10 → cycle 2: resp_rdata=0xDEADBEEF.
- SB addr 0x11 data 0x123456AA over 0xDEADBEEF → cycle 1: mem_rd_en=1. Cycle 2: mem_wr_en=1, mem_wr_data=0xDEADAAEF. Cycle 3: resp_valid. A following SH 0x12 data 0x00001234 writes 0x1234AAEF.
- Loads on word 0xDEADBEEF at 0x10:
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD.
  - LB 0x10 → 0xFFFFFFEF.
- Errors:
  - LW 0x12 → cycle 1: resp_valid=1, resp_err=1, resp_rdata=0. No mem strobe in any cycle.
  - SH 0x11 → same response; memory unchanged.
  - Load funct3=011 → err=1.
- Drop rst_n in the RMW_RD cycle of SB 0x10 → mem_wr_en is never asserted and memory still reads 0xDEADBEEF. After release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-only data memory: aligns strobes to words,
// extends load lanes and merges byte/halfword stores by read-modify-write.
module lsu_mem_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic             i_req_we,
   input  logic [2:0]       i_req_funct3,
   input  logic [WIDTH-1:0] i_req_addr,
   input  logic [WIDTH-1:0] i_req_wdata,
   output logic             o_resp_valid,
   output logic             o_resp_err,
   output logic [WIDTH-1:0] o_resp_rdata,
   output logic             o_mem_rd_en,
   output logic             o_mem_wr_en,
   output logic [WIDTH-1:0] o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wr_data,
   input  logic [WIDTH-1:0] i_mem_rd_data
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t           r_state;
   logic [2:0]       r_funct3;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_req_ready;
   logic             r_resp_valid;
   logic             r_resp_err;
   logic [WIDTH-1:0] r_resp_rdata;
   logic             r_mem_rd_en;
   logic             r_mem_wr_en;
   logic             w_accept;

   function automatic logic f_req_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic err;
      case (f3)
         3'b000:  err = 1'b0;
         3'b001:  err = a[0];
         3'b010:  err = (a != 2'b00);
         3'b100:  err = we;
         3'b101:  err = we | a[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

   function automatic logic [WIDTH-1:0] f_load_ext(input logic [2:0] f3,
                                                   input logic [1:0] lane,
                                                   input logic [WIDTH-1:0] word);
      logic [7:0]       b;
      logic [15:0]      h;
      logic [WIDTH-1:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{(WIDTH-8){b[7]}}, b};
         3'b001:  res = {{(WIDTH-16){h[15]}}, h};
         3'b010:  res = word;
         3'b100:  res = {{(WIDTH-8){1'b0}}, b};
         3'b101:  res = {{(WIDTH-16){1'b0}}, h};
         default: res = {WIDTH{1'b0}};
      endcase
      return res;
   endfunction

   function automatic logic [WIDTH-1:0] f_store_merge(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [WIDTH-1:0] old,
                                                      input logic [WIDTH-1:0] wd);
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] ins;
      case (f3)
         3'b000: begin
            mask = {{(WIDTH-8){1'b0}}, 8'hFF} << {lane, 3'b000};
            ins  = {{(WIDTH-8){1'b0}}, wd[7:0]} << {lane, 3'b000};
         end
         3'b001: begin
            mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
            ins  = {{(WIDTH-16){1'b0}}, wd[15:0]} << {lane[1], 4'b0000};
         end
         default: begin
            mask = {WIDTH{1'b1}};
            ins  = wd;
         end
      endcase
      return (old & ~mask) | (ins & mask);
   endfunction

   assign w_accept      = i_req_valid & r_req_ready;
   assign o_req_ready   = r_req_ready;
   assign o_resp_valid  = r_resp_valid;
   assign o_resp_err    = r_resp_err;
   assign o_resp_rdata  = r_resp_rdata;
   assign o_mem_rd_en   = r_mem_rd_en;
   assign o_mem_wr_en   = r_mem_wr_en;
   assign o_mem_addr    = {r_addr[WIDTH-1:2], 2'b00};
   assign o_mem_wr_data = r_wdata;

   // Request FSM; every output is set on the transition into the state that owns it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_funct3     <= 3'b000;
         r_addr       <= {WIDTH{1'b0}};
         r_wdata      <= {WIDTH{1'b0}};
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= {WIDTH{1'b0}};
         r_mem_rd_en  <= 1'b0;
         r_mem_wr_en  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_funct3    <= i_req_funct3;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_req_ready <= 1'b0;
                  if (f_req_err(i_req_we, i_req_funct3, i_req_addr[1:0])) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= {WIDTH{1'b0}};
                  end else if (!i_req_we) begin
                     r_state     <= ST_LOAD;
                     r_mem_rd_en <= 1'b1;
                  end else if (i_req_funct3 == 3'b010) begin
                     r_state     <= ST_WRITE;
                     r_mem_wr_en <= 1'b1;
                  end else begin
                     r_state     <= ST_RMW_RD;
                     r_mem_rd_en <= 1'b1;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               r_mem_rd_en  <= 1'b0;
               r_resp_rdata <= f_load_ext(r_funct3, r_addr[1:0], i_mem_rd_data);
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_state      <= ST_RESP;
            end
            ST_RMW_RD: begin
               r_mem_rd_en <= 1'b0;
               r_wdata     <= f_store_merge(r_funct3, r_addr[1:0], i_mem_rd_data, r_wdata);
               r_mem_wr_en <= 1'b1;
               r_state     <= ST_WRITE;
            end
            ST_WRITE: begin
               r_mem_wr_en  <= 1'b0;
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= {WIDTH{1'b0}};
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_mem_rd_en  <= 1'b0;
               r_mem_wr_en  <= 1'b0;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word memory model and hand-computed expectations.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   logic [31:0] mem [0:255] = '{default: 32'h0};

   int n_vec = 0;
   int n_mis = 0;

   int          t_lat;
   int          t_rd_cnt;
   int          t_wr_cnt;
   int          t_rd_cyc;
   int          t_wr_cyc;
   logic [31:0] t_rdata;
   logic        t_err;
   logic [31:0] t_wr_data;
   logic [31:0] t_wr_addr;
   logic [31:0] t_rd_addr;
   logic        t_after_valid;
   logic        t_after_ready;
   logic        seen_wr;
   logic        seen_rv;

   lsu_mem_ctrl #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_we      (req_we),
      .i_req_funct3  (req_funct3),
      .i_req_addr    (req_addr),
      .i_req_wdata   (req_wdata),
      .o_resp_valid  (resp_valid),
      .o_resp_err    (resp_err),
      .o_resp_rdata  (resp_rdata),
      .o_mem_rd_en   (mem_rd_en),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_addr    (mem_addr),
      .o_mem_wr_data (mem_wr_data),
      .i_mem_rd_data (mem_rd_data)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and record strobe/response activity until resp_valid (bounded).
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      t_lat = -1; t_rd_cnt = 0; t_wr_cnt = 0; t_rd_cyc = -1; t_wr_cyc = -1;
      t_rdata = 32'hX; t_err = 1'bX; t_wr_data = 32'h0; t_wr_addr = 32'h0; t_rd_addr = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         if (mem_rd_en) begin
            t_rd_cnt++;
            if (t_rd_cyc < 0) begin
               t_rd_cyc  = c;
               t_rd_addr = mem_addr;
            end
         end
         if (mem_wr_en) begin
            t_wr_cnt++;
            t_wr_cyc  = c;
            t_wr_data = mem_wr_data;
            t_wr_addr = mem_addr;
         end
         if (resp_valid) begin
            t_lat   = c;
            t_rdata = resp_rdata;
            t_err   = resp_err;
            step();
            t_after_valid = resp_valid;
            t_after_ready = req_ready;
            break;
         end
         step();
      end
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
      run(1'b0, f3, a, 32'h0);
      chk({tag, "_lat"}, 32'(t_lat), 32'd2);
      chk({tag, "_rdata"}, t_rdata, exp);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0000_0020; req_wdata = 32'hCAFE_F00D;
      repeat (3) step();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      req_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) step();
      chk("rst_no_accept_mem", mem[8], 32'h0);
      chk("rst_no_accept_valid", 32'(resp_valid), 32'd0);

      run(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      chk("sw_wr_cyc", 32'(t_wr_cyc), 32'd1);
      chk("sw_wr_addr", t_wr_addr, 32'h10);
      chk("sw_wr_data", t_wr_data, 32'hDEAD_BEEF);
      chk("sw_lat", 32'(t_lat), 32'd2);
      chk("sw_err", 32'(t_err), 32'd0);
      chk("sw_rd_cnt", 32'(t_rd_cnt), 32'd0);
      chk("sw_after_valid", 32'(t_after_valid), 32'd0);
      chk("sw_after_ready", 32'(t_after_ready), 32'd1);

      load_chk("lw", 3'b010, 32'h10, 32'hDEAD_BEEF);
      chk("lw_rd_cyc", 32'(t_rd_cyc), 32'd1);
      chk("lw_rd_addr", t_rd_addr, 32'h10);
      chk("lw_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

      run(1'b1, 3'b000, 32'h11, 32'h1234_56AA);
      chk("sb_rd_cyc", 32'(t_rd_cyc), 32'd1);
      chk("sb_wr_cyc", 32'(t_wr_cyc), 32'd2);
      chk("sb_wr_data", t_wr_data, 32'hDEAD_AAEF);
      chk("sb_lat", 32'(t_lat), 32'd3);
      chk("sb_rdata_zero", t_rdata, 32'h0);

      run(1'b1, 3'b001, 32'h12, 32'h0000_1234);
      chk("sh_wr_data", t_wr_data, 32'h1234_AAEF);
      chk("sh_lat", 32'(t_lat), 32'd3);
      chk("sh_mem", mem[4], 32'h1234_AAEF);

      run(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      load_chk("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE);
      load_chk("lbu13", 3'b100, 32'h13, 32'h0000_00DE);
      load_chk("lh12", 3'b001, 32'h12, 32'hFFFF_DEAD);
      load_chk("lhu12", 3'b101, 32'h12, 32'h0000_DEAD);
      load_chk("lb10", 3'b000, 32'h10, 32'hFFFF_FFEF);
      load_chk("lbu11", 3'b100, 32'h11, 32'h0000_00BE);

      run(1'b0, 3'b010, 32'h12, 32'h0);
      chk("err_lw_lat", 32'(t_lat), 32'd1);
      chk("err_lw_err", 32'(t_err), 32'd1);
      chk("err_lw_rdata", t_rdata, 32'h0);
      chk("err_lw_strobes", 32'(t_rd_cnt + t_wr_cnt), 32'd0);

      run(1'b1, 3'b001, 32'h11, 32'h0000_5555);
      chk("err_sh_lat", 32'(t_lat), 32'd1);
      chk("err_sh_err", 32'(t_err), 32'd1);
      chk("err_sh_strobes", 32'(t_rd_cnt + t_wr_cnt), 32'd0);
      chk("err_sh_mem", mem[4], 32'hDEAD_BEEF);

      run(1'b0, 3'b011, 32'h10, 32'h0);
      chk("err_f3_011", 32'(t_err), 32'd1);
      run(1'b1, 3'b100, 32'h10, 32'h0);
      chk("err_sbu", 32'(t_err), 32'd1);
      chk("err_sbu_mem", mem[4], 32'hDEAD_BEEF);
      run(1'b0, 3'b101, 32'h13, 32'h0);
      chk("err_lhu_mis", 32'(t_err), 32'd1);

      run(1'b1, 3'b010, 32'hABCD_0014, 32'h0BAD_CAFE);
      chk("hi_addr_wr", t_wr_addr, 32'hABCD_0014);
      load_chk("hi_addr_lw", 3'b010, 32'hABCD_0016 & 32'hFFFF_FFFC, 32'h0BAD_CAFE);
      chk("hi_addr_rd", t_rd_addr, 32'hABCD_0014);

      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
      step();
      chk("b2b_c1_rd", 32'(mem_rd_en), 32'd1);
      step();
      chk("b2b_c2_valid", 32'(resp_valid), 32'd1);
      chk("b2b_c2_ready", 32'(req_ready), 32'd0);
      step();
      chk("b2b_c3_valid", 32'(resp_valid), 32'd0);
      chk("b2b_c3_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      chk("b2b_c4_rd", 32'(mem_rd_en), 32'd1);
      step();
      chk("b2b_c5_valid", 32'(resp_valid), 32'd1);
      chk("b2b_c5_rdata", resp_rdata, 32'hDEAD_BEEF);
      step();

      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0000_0055;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("arst_rmw_rd", 32'(mem_rd_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_rd_drop", 32'(mem_rd_en), 32'd0);
      chk("arst_wr_low", 32'(mem_wr_en), 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd1);
      seen_wr = 1'b0; seen_rv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 1) rst_n = 1'b1;
         seen_wr = seen_wr | mem_wr_en;
         seen_rv = seen_rv | resp_valid;
      end
      chk("arst_no_wr", 32'(seen_wr), 32'd0);
      chk("arst_no_resp", 32'(seen_rv), 32'd0);
      chk("arst_mem", mem[4], 32'hDEAD_BEEF);
      chk("arst_ready_after", 32'(req_ready), 32'd1);
      load_chk("arst_lw", 3'b010, 32'h10, 32'hDEAD_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
